// File: rtl/quad_encoder_emulator_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
// The us-to-cycles helper is the same conversion the decoder side uses,
// so both ends agree on timing for a given clock.
package quad_encoder_emulator_pkg;

    // One IDLE state plus one state per quadrature edge of a detent click.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_E1   = 3'd1,
        ST_E2   = 3'd2,
        ST_E3   = 3'd3,
        ST_E4   = 3'd4
    } enc_state_e;

    localparam int LFSR_W = 16;

    // Microseconds to clock cycles for an integer-MHz clock.
    function automatic int us_to_cycles(input int clk_mhz, input int us);
        return clk_mhz * us;
    endfunction

    // Edge sequence of one click: IDLE -> E1 -> E2 -> E3 -> E4 -> IDLE.
    function automatic enc_state_e next_edge(input enc_state_e s);
        case (s)
            ST_IDLE: return ST_E1;
            ST_E1:   return ST_E2;
            ST_E2:   return ST_E3;
            ST_E3:   return ST_E4;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/quad_encoder_emulator_if.sv
// Step-request handshake and A/B encoder lines of the emulator.
// master = step requester / line observer, slave = the emulator itself.
interface quad_encoder_emulator_if;
    logic step_valid_i;
    logic step_dir_i;
    logic step_ready_o;
    logic step_done_o;
    logic a_o;
    logic b_o;

    modport master (
        output step_valid_i, step_dir_i,
        input  step_ready_o, step_done_o, a_o, b_o
    );

    modport slave (
        input  step_valid_i, step_dir_i,
        output step_ready_o, step_done_o, a_o, b_o
    );
endinterface

// File: rtl/quad_encoder_emulator_bounce_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the contact-bounce noise
// source. Only compiled when QUAD_ENC_BOUNCE_EN is defined, since the clean
// build has no use for it.
`ifdef QUAD_ENC_BOUNCE_EN
module bounce_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bit_o
);
    logic [15:0] lfsr_q, lfsr_d;

    // An all-zero state would lock the register up.
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("bounce_lfsr: SEED must be non-zero");
    end

    // Shift in the tap XOR when enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i)
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Reset restarts the sequence from the seed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign bit_o = lfsr_q[0];
endmodule
`endif

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns accepted step requests into one
// detent click (four Gray-coded A/B edges, PHASE_CYC cycles apart).
// Optional contact bounce on the moving line: define QUAD_ENC_BOUNCE_EN.
// All outputs come straight from flops.
module quad_encoder_emulator
    import quad_encoder_emulator_pkg::*;
#(
    parameter int          CLOCK_FREQ_MHZ = 100,
    parameter int          PHASE_US       = 150,
    parameter int          BOUNCE_US      = 50,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    quad_encoder_emulator_if.slave    bus
);
    localparam int PHASE_CYC = us_to_cycles(CLOCK_FREQ_MHZ, PHASE_US);
    localparam int CNT_W     = $clog2(PHASE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // A bounce window as long as the phase would never let the line settle.
    if (BOUNCE_US >= PHASE_US) begin : g_bad_bounce
        $error("quad_encoder_emulator: BOUNCE_US must be smaller than PHASE_US");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("quad_encoder_emulator: LFSR_SEED must be non-zero");
    end

    enc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             lead_lvl, trail_lvl;

`ifdef QUAD_ENC_BOUNCE_EN
    localparam int BOUNCE_CYC = us_to_cycles(CLOCK_FREQ_MHZ, BOUNCE_US);
    // Counter runs PHASE_CYC-1 down to 0; the first BOUNCE_CYC cycles of a
    // state are those with the counter at or above this threshold.
    localparam logic [CNT_W-1:0] BOUNCE_THR = CNT_W'(PHASE_CYC - BOUNCE_CYC);

    logic lfsr_bit;
    logic move_lead;

    bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .bit_o (lfsr_bit)
    );
`endif

    // State register plus registered outputs; reset parks both lines high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            a_q     <= 1'b1;
            b_q     <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next state: accept in IDLE, otherwise count down and advance on zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (state_q == ST_IDLE) begin
            if (bus.step_valid_i) begin
                state_d = ST_E1;
                cnt_d   = CNT_LOAD;
                dir_d   = bus.step_dir_i;
            end
        end else if (cnt_q == '0) begin
            state_d = next_edge(state_q);
            cnt_d   = (state_d == ST_IDLE) ? '0 : CNT_LOAD;
        end else begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Outputs: line levels follow the upcoming state so edges land exactly
    // one cycle after the state change is decided.
    always_comb begin
        lead_lvl  = 1'b1;
        trail_lvl = 1'b1;
        case (state_d)
            ST_E1: lead_lvl = 1'b0;
            ST_E2: begin lead_lvl = 1'b0; trail_lvl = 1'b0; end
            ST_E3: trail_lvl = 1'b0;
            default: ;
        endcase
`ifdef QUAD_ENC_BOUNCE_EN
        // Only the line that just moved chatters; the other one stays put.
        move_lead = (state_d == ST_E1) || (state_d == ST_E3);
        if (state_d != ST_IDLE && cnt_d >= BOUNCE_THR) begin
            if (move_lead) lead_lvl  = lfsr_bit;
            else           trail_lvl = lfsr_bit;
        end
`endif
        a_d     = dir_d ? lead_lvl  : trail_lvl;
        b_d     = dir_d ? trail_lvl : lead_lvl;
        ready_d = (state_d == ST_IDLE);
        // Registered, so raise it one cycle early: it lands on the last E4 cycle.
        done_d  = (state_q == ST_E4) && (cnt_q == CNT_ONE);
    end

    assign bus.a_o          = a_q;
    assign bus.b_o          = b_q;
    assign bus.step_ready_o = ready_q;
    assign bus.step_done_o  = done_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Bench for quad_encoder_emulator at 10 MHz, PHASE_CYC=20, BOUNCE_CYC=10.
// Line/handshake events go through an expected-event queue; fixed-offset
// level checks come from a vector table.
module tb_quad_encoder_emulator;
    localparam int PH = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    quad_encoder_emulator_if bus();

    quad_encoder_emulator #(
        .CLOCK_FREQ_MHZ (10),
        .PHASE_US       (2),
        .BOUNCE_US      (1),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kinds: 0 A->0, 1 A->1, 2 B->0, 3 B->1, 4 done, 5 ready->0, 6 ready->1
    typedef struct { int cyc; int kind; } ev_t;
    ev_t sb_q[$];

    typedef struct { int off; bit lead; bit trail; bit rdy; bit done; } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_take(input int kind);
        ev_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: event kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = sb_q.pop_front();
            if (e.cyc != cyc || e.kind != kind) begin
                n_bad++;
                $display("FAIL sb_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    function automatic void push(input int c, input int k);
        ev_t e;
        e.cyc = c; e.kind = k;
        sb_q.push_back(e);
    endfunction

    // Expected events of one full step accepted in cycle t.
    function automatic void push_step(input int t, input bit dir);
`ifndef QUAD_ENC_BOUNCE_EN
        push(t + 1, dir ? 0 : 2);
`endif
        push(t + 1, 5);
`ifndef QUAD_ENC_BOUNCE_EN
        push(t + 1 + PH,     dir ? 2 : 0);
        push(t + 1 + 2 * PH, dir ? 1 : 3);
        push(t + 1 + 3 * PH, dir ? 3 : 1);
`endif
        push(t + 4 * PH,     4);
        push(t + 4 * PH + 1, 6);
    endfunction

    // Observer: turns output activity into events for the scoreboard.
    logic pa = 1'b1, pb = 1'b1, pr = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            pa = bus.a_o; pb = bus.b_o; pr = bus.step_ready_o;
        end else begin
`ifndef QUAD_ENC_BOUNCE_EN
            if (bus.a_o !== pa) sb_take(bus.a_o ? 1 : 0);
            if (bus.b_o !== pb) sb_take(bus.b_o ? 3 : 2);
`endif
            if (bus.step_done_o) sb_take(4);
            if (bus.step_ready_o !== pr) sb_take(bus.step_ready_o ? 6 : 5);
            pa = bus.a_o; pb = bus.b_o; pr = bus.step_ready_o;
        end
    end

    // Advance to the negedge of cycle k (always at least one negedge).
    task automatic wait_cyc(input int k);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < k && g < 2000);
        if (cyc != k) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, k);
        end
    endtask

    task automatic start_step(input bit dir, output int t);
        @(posedge clk); #1;
        bus.step_dir_i   = dir;
        bus.step_valid_i = 1'b1;
        t = cyc;
    endtask

    task automatic drop_valid_next();
        @(posedge clk); #1;
        bus.step_valid_i = 1'b0;
    endtask

    task automatic run_table(input bit dir);
        int t;
        start_step(dir, t);
        push_step(t, dir);
        for (int i = 0; i < 11; i++) begin
            wait_cyc(t + tbl[i].off);
`ifndef QUAD_ENC_BOUNCE_EN
            check(dir ? "tbl_a" : "tbl_a_left", bus.a_o, dir ? tbl[i].lead  : tbl[i].trail);
            check(dir ? "tbl_b" : "tbl_b_left", bus.b_o, dir ? tbl[i].trail : tbl[i].lead);
`endif
            check("tbl_ready", bus.step_ready_o, tbl[i].rdy);
            check("tbl_done",  bus.step_done_o,  tbl[i].done);
            if (tbl[i].off == 0) drop_valid_next();
        end
        repeat (5) @(posedge clk);
    endtask

    initial begin
        int t;
        bus.step_valid_i = 1'b0;
        bus.step_dir_i   = 1'b0;
        tbl[0]  = '{0,  1, 1, 1, 0};
        tbl[1]  = '{1,  0, 1, 0, 0};
        tbl[2]  = '{20, 0, 1, 0, 0};
        tbl[3]  = '{21, 0, 0, 0, 0};
        tbl[4]  = '{40, 0, 0, 0, 0};
        tbl[5]  = '{41, 1, 0, 0, 0};
        tbl[6]  = '{60, 1, 0, 0, 0};
        tbl[7]  = '{61, 1, 1, 0, 0};
        tbl[8]  = '{79, 1, 1, 0, 0};
        tbl[9]  = '{80, 1, 1, 0, 1};
        tbl[10] = '{81, 1, 1, 1, 0};

        // Reset state.
        repeat (3) @(posedge clk); #2;
        check("rst_a", bus.a_o, 1);
        check("rst_b", bus.b_o, 1);
        check("rst_ready", bus.step_ready_o, 1);
        check("rst_done", bus.step_done_o, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Idle: nothing moves.
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("idle_a", bus.a_o, 1);
        check("idle_b", bus.b_o, 1);
        check("idle_ready", bus.step_ready_o, 1);
        check("idle_done", bus.step_done_o, 0);

        // Single steps, both directions.
        run_table(1'b1);
        run_table(1'b0);

        // Request while busy is dropped; latched direction is kept.
        start_step(1'b1, t);
        push_step(t, 1'b1);
        wait_cyc(t);
        drop_valid_next();
        wait_cyc(t + 29);
        @(posedge clk); #1;
        bus.step_dir_i = 1'b0; bus.step_valid_i = 1'b1;
        drop_valid_next();
        wait_cyc(t + 100);
        check("busy_ignored_queue", sb_q.size(), 0);

        // Held request: three back-to-back steps.
        start_step(1'b0, t);
        push_step(t, 1'b0);
        push_step(t + 4 * PH + 1, 1'b0);
        push_step(t + 2 * (4 * PH + 1), 1'b0);
        wait_cyc(t + 2 * (4 * PH + 1));
        drop_valid_next();
        wait_cyc(t + 3 * (4 * PH + 1) + 20);
        check("b2b_queue", sb_q.size(), 0);

        // Reset mid-step: lines high at once, no done, ready after release.
        start_step(1'b1, t);
`ifndef QUAD_ENC_BOUNCE_EN
        push(t + 1, 0);
`endif
        push(t + 1, 5);
`ifndef QUAD_ENC_BOUNCE_EN
        push(t + 1 + PH, 2);
`endif
        wait_cyc(t);
        drop_valid_next();
        wait_cyc(t + 29);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("midrst_a", bus.a_o, 1);
        check("midrst_b", bus.b_o, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", bus.step_ready_o, 1);
        check("midrst_done", bus.step_done_o, 0);
        repeat (100) @(posedge clk);
        check("midrst_queue", sb_q.size(), 0);

`ifdef QUAD_ENC_BOUNCE_EN
        // Bounce: moving line chatters for 10 cycles then holds; other line steady.
        begin
            bit mv, prev, set_mv, set_ot, ot;
            int tog;
            start_step(1'b1, t);
            push_step(t, 1'b1);
            wait_cyc(t);
            drop_valid_next();
            for (int k = 0; k < 4; k++) begin
                set_mv = (k >= 2);
                set_ot = (k == 0) || (k == 3);
                prev   = ~set_mv;
                tog    = 0;
                for (int o = 0; o < PH; o++) begin
                    wait_cyc(t + 1 + PH * k + o);
                    mv = (k % 2 == 0) ? bus.a_o : bus.b_o;
                    ot = (k % 2 == 0) ? bus.b_o : bus.a_o;
                    check("bounce_other_line", ot, set_ot);
                    if (o < 10) begin
                        if (mv != prev) tog++;
                        prev = mv;
                        if (o == 9) check("bounce_toggled", (tog > 0) ? 1 : 0, 1);
                    end else begin
                        check("bounce_settled", mv, set_mv);
                    end
                end
            end
            wait_cyc(t + 4 * PH + 10);
            check("bounce_queue", sb_q.size(), 0);
        end
`endif

        check("final_queue", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
